stream_out_serializer: RTL
==========================

// Module: stream_out_serializer
// PURPOSE
//  Receiving end of the 1536-bit output stream. Accepts wide beats (data plus
//  per-lane last flags) and re-emits them as a narrow AXI-stream toward the DMA.
//  - Lane 0 is sent first.
//  - Each packet is truncated at the first flagged lane.
//  Full throughput: one narrow beat per clock while m_tready is high, with no
//  bubble between wide beats.
// PARAMETERS
//  WIDE_W    1536  wide input data width (bits)
//  NARROW_W  64    narrow output width; LANES = WIDE_W/NARROW_W = 24 (localparam)
//  CNT_W     5     lane counter width, >= clog2(LANES)
// PORTS
//  clk       in   1        single clock; all logic rising-edge
//  rst       in   1        asynchronous, active-high reset
//  s_tdata   in   WIDE_W   wide beat; lane i = bits [i*NARROW_W +: NARROW_W]
//  s_tvalid  in   1        wide beat valid
//  s_tready  out  1        wide beat accepted when s_tvalid & s_tready
//  s_tlast   in   LANES    per-lane end-of-packet flags
//  m_tdata   out  NARROW_W narrow beat = current lane of held wide beat
//  m_tvalid  out  1        narrow beat valid
//  m_tready  in   1        downstream ready
//  m_tlast   out  1        narrow beat is the final lane of a packet
// BEHAVIOUR
//  - Reset (async assert, sync release):
//      - buffer empty, lane counter = 0, end lane = LANES-1, end flag = 0.
//      - Outputs: m_tvalid = 0, m_tlast = 0, m_tdata = 0, s_tready = 0.
//      - s_tready goes to 1 on the first clock after release.
//  - States:
//      - EMPTY: s_tready = 1, m_tvalid = 0.
//      - SEND: m_tvalid = 1, m_tdata = lane[cnt] of the held beat.
//  - Capture (wide handshake): latch s_tdata.
//      - end = index of the lowest set s_tlast bit, end flag = 1.
//      - If s_tlast == 0: end = LANES-1, end flag = 0.
//      - cnt <= 0; go to SEND. Latency from capture to first m_tvalid = 1 cycle.
//  - In SEND, a narrow handshake (m_tvalid & m_tready):
//      - cnt != end: cnt <= cnt+1.
//      - cnt == end: beat done. Lanes above end are discarded, never emitted.
//  - s_tready in SEND = m_tready & (cnt == end).
//      - The last lane and the next wide beat can handshake in the same cycle.
//      - Next cycle then presents lane 0 of the new beat (no bubble).
//      - If no new beat arrives in that cycle, return to EMPTY.
//  - m_tlast = SEND & (cnt == end) & end flag.
//      - An unflagged beat streams all 24 lanes with m_tlast = 0; the packet
//        continues in the next wide beat.
//  - AXIS stability: while m_tvalid & !m_tready, m_tdata and m_tlast hold.
//    s_tready is combinational from m_tready and registered state only, never
//    from s_tvalid.
//  - s_tlast with multiple bits set: only the lowest set bit is honoured; the
//    remainder of the beat is dropped.
//  - s_tlast[0] set: exactly one narrow beat is emitted, with m_tlast = 1.
//  - Reset mid-packet: held beat discarded and m_tvalid drops immediately
//    (async). No partial-packet recovery; upstream re-sends.
// CONFIGURATION
//  - SER_PKT_CNT_EN defined:
//      - Adds output port pkt_count [15:0].
//      - Increments on every narrow handshake with m_tlast = 1; wraps
//        0xFFFF -> 0; reset to 0.
//      - Adds output port drop_count [15:0]: +1 on each capture whose end
//        < LANES-1 (lanes truncated); wraps; reset to 0.
//  - Not defined: neither port exists and neither counter is built. Data-path
//    behaviour is identical in both builds.
// TESTING
//  - Reset, then send one beat (lane i = 64'hA000+i, s_tlast = 0) with
//    m_tready = 1 -> 24 beats A000..A017 on consecutive cycles, all with
//    m_tlast = 0.
//  - Beat with s_tlast = 24'h000020 -> lanes 0..5 emitted; m_tlast = 1 on
//    lane 5 only; lanes 6..23 never appear.
//  - Two beats back-to-back, s_tvalid held high, second beat with
//    s_tlast[23] = 1 -> 48 beats on 48 consecutive cycles; s_tready pulses in
//    the cycle of lane 23; m_tlast on beat 48.
//  - Randomise m_tready (50%) over 100 random packets -> output equals the
//    reference lane sequence; m_tdata/m_tlast stable whenever stalled;
//    no beats lost.
//  - Multiple flags s_tlast = 24'h800104 -> 3 beats, m_tlast on lane 2.
//    s_tlast = 24'h000001 -> single beat with m_tlast = 1.
//  - Assert rst mid-beat at lane 10 -> m_tvalid = 0 immediately. After
//    release, s_tready = 1 and the next beat restarts at lane 0.
//    With SER_PKT_CNT_EN: pkt_count and drop_count read 0.

Source files
------------

// File: rtl/stream_out_serializer.sv
// stream_out_serializer: wide-beat to narrow AXI-stream serializer.
// Optional build macro SER_PKT_CNT_EN adds pkt_count/drop_count ports.
module stream_out_serializer #(
  parameter int WIDE_W   = 1536,
  parameter int NARROW_W = 64,
  parameter int CNT_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDE_W-1:0]            s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [WIDE_W/NARROW_W-1:0]   s_tlast,
  output logic [NARROW_W-1:0]          m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast
`ifdef SER_PKT_CNT_EN
  ,
  output logic [15:0]                  pkt_count,
  output logic [15:0]                  drop_count
`endif
);

  localparam int LANES = WIDE_W / NARROW_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_EMPTY,
    ST_SEND
  } state_t;

  state_t              state;
  logic [WIDE_W-1:0]   buf_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    end_lane;
  logic                end_flag;

  logic [CNT_W-1:0]    first_idx;
  logic                any_last;
  logic                at_end;
  logic                capture;
  logic                narrow_hs;

  // Lowest flagged lane of the incoming beat; unflagged beats run to the top lane.
  always_comb begin
    first_idx = LAST_LANE;
    any_last  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (s_tlast[i]) begin
        first_idx = CNT_W'(i);
        any_last  = 1'b1;
      end
    end
  end

  assign at_end    = (cnt == end_lane);
  assign m_tvalid  = (state == ST_SEND);
  assign m_tlast   = m_tvalid & at_end & end_flag;
  assign narrow_hs = m_tvalid & m_tready;
  assign capture   = s_tvalid & s_tready;

  // Ready never looks at s_tvalid; last lane and next wide beat may overlap.
  always_comb begin
    s_tready = 1'b0;
    unique case (state)
      ST_EMPTY: s_tready = 1'b1;
      ST_SEND:  s_tready = m_tready & at_end;
      default:  s_tready = 1'b0;
    endcase
  end

  // Output lane is gated so idle/reset data reads as zero.
  always_comb begin
    m_tdata = '0;
    if (m_tvalid) begin
      m_tdata = buf_q[int'(cnt)*NARROW_W +: NARROW_W];
    end
  end

  // Held beat needs no reset: it is only visible while in SEND.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= s_tdata;
    end
  end

  // Control FSM: lane counter, end marker and EMPTY/SEND sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RST;
      cnt      <= '0;
      end_lane <= LAST_LANE;
      end_flag <= 1'b0;
    end else if (capture) begin
      state    <= ST_SEND;
      cnt      <= '0;
      end_lane <= first_idx;
      end_flag <= any_last;
    end else begin
      unique case (state)
        ST_RST: begin
          state <= ST_EMPTY;
        end
        ST_EMPTY: begin
          state <= ST_EMPTY;
        end
        ST_SEND: begin
          if (narrow_hs) begin
            if (!at_end) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

`ifdef SER_PKT_CNT_EN
  // Completed-packet and truncated-beat statistics, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (narrow_hs && m_tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (capture && (first_idx != LAST_LANE)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
